// File: rtl/cpu_control_unit_p.sv
// Multi-cycle control unit for the 16-bit CPU: handshaked fetch, decode, and Datapath control.
// Optional macro CU_BRANCH_EN builds the JZ/JMP states; without it opcodes 6/7 decode to NOOP.
module cpu_control_unit_p #(
    parameter int PC_W   = 8,
    parameter int RF_AW  = 4,
    parameter int OP_W   = 4,
    parameter int ALU_SW = 3
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [OP_W+3*RF_AW-1:0]   IR_In,
    input  logic                      I_Ready,
    input  logic                      ALU_Zero,
    output logic                      I_Rd,
    output logic [PC_W-1:0]           PC_Out,
    output logic [OP_W+3*RF_AW-1:0]   IR_Out,
    output logic [3:0]                State,
    output logic [3:0]                NextState,
    output logic [2*RF_AW-1:0]        D_Addr,
    output logic                      D_Wr,
    output logic                      RF_s,
    output logic                      RF_W_en,
    output logic [RF_AW-1:0]          RF_Ra_Addr,
    output logic [RF_AW-1:0]          RF_Rb_Addr,
    output logic [RF_AW-1:0]          RF_W_Addr,
    output logic [ALU_SW-1:0]         ALU_s0,
    output logic                      Halted
);

    localparam int IW = OP_W + 3*RF_AW;

    localparam logic [OP_W-1:0] OP_NOOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(5);
`ifdef CU_BRANCH_EN
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(7);
`endif

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
`ifdef CU_BRANCH_EN
        ,
        S_JZ     = 4'd10,
        S_JMP    = 4'd11
`endif
    } state_t;

    state_t              cur_state;
    state_t              nxt_state;
    logic [PC_W-1:0]     pc;
    logic [IW-1:0]       ir;
    logic                halted;

    logic [OP_W-1:0]     op;
    logic [RF_AW-1:0]    f2;
    logic [RF_AW-1:0]    f1;
    logic [RF_AW-1:0]    f0;
    logic [2*RF_AW-1:0]  addr_field;

    assign op         = ir[IW-1:IW-OP_W];
    assign f2         = ir[3*RF_AW-1:2*RF_AW];
    assign f1         = ir[2*RF_AW-1:RF_AW];
    assign f0         = ir[RF_AW-1:0];
    assign addr_field = ir[3*RF_AW-1:RF_AW];

`ifdef CU_BRANCH_EN
    // Widen to whichever is larger so the target is zero-extended or truncated to PC_W.
    localparam int AW = 2*RF_AW;
    localparam int WW = (PC_W > AW) ? PC_W : AW;
    logic [WW-1:0]   addr_wide;
    logic [PC_W-1:0] jump_target;
    logic            take_jump;

    assign addr_wide   = WW'(addr_field);
    assign jump_target = addr_wide[PC_W-1:0];
    assign take_jump   = (cur_state == S_JMP) || ((cur_state == S_JZ) && ALU_Zero);
`else
    logic unused_alu_zero;
    assign unused_alu_zero = ALU_Zero;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_state <= S_INIT;
            pc        <= '0;
            ir        <= '0;
            halted    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_FETCH && I_Ready) begin
                ir <= IR_In;
                pc <= pc + PC_W'(1);
            end
`ifdef CU_BRANCH_EN
            if (take_jump) begin
                pc <= jump_target;
            end
`endif
            if (cur_state == S_HALT) begin
                halted <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        I_Rd       = 1'b0;
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        RF_W_Addr  = '0;
        ALU_s0     = '0;
        case (cur_state)
            S_INIT: nxt_state = S_FETCH;
            S_FETCH: begin
                I_Rd = 1'b1;
                if (I_Ready) begin
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_NOOP:  nxt_state = S_NOOP;
                    OP_STORE: nxt_state = S_STORE;
                    OP_LOAD:  nxt_state = S_LOAD_A;
                    OP_ADD:   nxt_state = S_ADD;
                    OP_SUB:   nxt_state = S_SUB;
                    OP_HALT:  nxt_state = S_HALT;
`ifdef CU_BRANCH_EN
                    OP_JZ:    nxt_state = S_JZ;
                    OP_JMP:   nxt_state = S_JMP;
`endif
                    default:  nxt_state = S_NOOP;
                endcase
            end
            S_NOOP: nxt_state = S_FETCH;
            S_STORE: begin
                D_Addr     = addr_field;
                D_Wr       = 1'b1;
                RF_Ra_Addr = f0;
                nxt_state  = S_FETCH;
            end
            // Two cycles so the synchronous data RAM has its read result ready on LOAD_B.
            S_LOAD_A: begin
                D_Addr    = addr_field;
                RF_s      = 1'b1;
                RF_W_Addr = f0;
                nxt_state = S_LOAD_B;
            end
            S_LOAD_B: begin
                D_Addr    = addr_field;
                RF_s      = 1'b1;
                RF_W_Addr = f0;
                RF_W_en   = 1'b1;
                nxt_state = S_FETCH;
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr = f2;
                RF_Rb_Addr = f1;
                RF_W_Addr  = f0;
                ALU_s0     = (cur_state == S_ADD) ? ALU_SW'(1) : ALU_SW'(2);
                RF_W_en    = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_HALT: nxt_state = S_HALT;
`ifdef CU_BRANCH_EN
            S_JZ, S_JMP: nxt_state = S_FETCH;
`endif
            default: nxt_state = S_INIT;
        endcase
    end

    assign State     = cur_state;
    assign NextState = nxt_state;
    assign PC_Out    = pc;
    assign IR_Out    = ir;
    assign Halted    = halted;

endmodule

// File: doc/cpu_control_unit_p.md
Name: cpu_control_unit_p

Overview:
- Parametrised multi-cycle control unit for the 16-bit CPU. It fetches from instruction memory through a ready handshake, decodes, and drives the Datapath control bundle.
- It generalises the current controller with configurable PC, register-address and ALU-select widths.
- New over the current controller: wait-state fetch, conditional and unconditional jumps, and a sticky Halted flag.
- It sits inside Processor between instruction ROM and Datapath.

Parameters:
- PC_W, 8, program counter width; instruction memory depth is 2**PC_W.
- RF_AW, 4, register-file address width; D_Addr width is 2*RF_AW.
- OP_W, 4, opcode width; IW = OP_W + 3*RF_AW (16 at defaults).
- ALU_SW, 3, ALU select width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IR_In  in  IW  instruction word from ROM, valid when I_Ready=1.
- I_Ready  in  1  ROM data-valid handshake.
- ALU_Zero  in  1  Datapath registered zero flag from the last ALU op.
- I_Rd  out  1  ROM read request.
- PC_Out  out  PC_W  program counter, also the ROM address.
- IR_Out  out  IW  instruction register.
- State  out  4  current FSM state code.
- NextState  out  4  next FSM state code.
- D_Addr  out  2*RF_AW  data memory address (IR[2*RF_AW+RF_AW-1:RF_AW]).
- D_Wr  out  1  data memory write enable.
- RF_s  out  1  register-file write mux select: 1=data memory, 0=ALU.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr  out  RF_AW each  register addresses.
- ALU_s0  out  ALU_SW  ALU op: 0=pass A, 1=A+B, 2=A-B.
- Halted  out  1  sticky halt indicator.

Behaviour:
- Reset (asynchronous, any state, mid-fetch included): State=INIT, PC=0, IR=0, Halted=0. All control outputs are 0.
- Instruction fields: op=IR[IW-1:IW-OP_W], f2/f1/f0 = the three RF_AW fields, MSB to LSB.
- State codes: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9, JZ=10, JMP=11.
- INIT -> FETCH unconditionally.
- FETCH:
  - I_Rd=1.
  - Holds while I_Ready=0; PC and IR are unchanged.
  - On a cycle with I_Ready=1: IR<=IR_In, PC<=PC+1 (wraps 2**PC_W-1 -> 0), go to DECODE.
- DECODE: one cycle, no side effects. Opcode dispatch: 0 NOOP, 1 STORE, 2 LOAD_A, 3 ADD, 4 SUB, 5 HALT, 6 JZ, 7 JMP. Any other value goes to NOOP.
- NOOP -> FETCH.
- STORE: D_Wr=1, D_Addr=IR addr field, RF_Ra_Addr=f0, ALU_s0=0 -> FETCH.
- LOAD_A: D_Addr driven, RF_s=1, RF_W_Addr=f0 -> LOAD_B.
- LOAD_B: same as LOAD_A plus RF_W_en=1 -> FETCH. The 2-cycle load covers the synchronous RAM read.
- ADD: RF_Ra=f2, RF_Rb=f1, RF_W_Addr=f0, ALU_s0=1, RF_s=0, RF_W_en=1 -> FETCH.
- SUB: as ADD but ALU_s0=2.
- JZ: if ALU_Zero=1 then PC<=addr field truncated/zero-extended to PC_W; otherwise PC is unchanged. -> FETCH.
- JMP: PC<=target unconditionally -> FETCH.
- HALT: Halted<=1, self-loop. Exit only by Reset.
- Control outputs are decoded combinationally from State and IR (Moore per state). Unlisted outputs are 0 in each state.
- NextState is the combinational next-state value.
- A jump target equal to the current PC is legal and loops.
- I_Ready asserted outside FETCH is ignored.

Optional Feature:
- CU_BRANCH_EN defined: JZ/JMP are decoded as above.
- CU_BRANCH_EN undefined: opcodes 6 and 7 decode to NOOP, the JZ/JMP states are not built, and ALU_Zero is unused.

Test Plan:
- Reset asserted mid-FETCH with I_Ready=0 -> State=0, PC_Out=0, IR_Out=0 immediately; INIT->FETCH on the first edge after release.
- ROM holds ADD 0x3210 with I_Ready low for 3 cycles -> State stays 1 for 3 cycles, then IR_Out=0x3210, PC=1. EXECUTE shows ALU_s0=1, Ra=2, Rb=1, W=0, RF_W_en=1.
- LOAD 0x2A53 -> D_Addr=0xA5 in states 4 and 5; RF_W_en=1 only in state 5 with RF_s=1 and RF_W_Addr=3.
- JZ 0x6400 with ALU_Zero=1 -> PC=0x40. With ALU_Zero=0 -> PC increments. With CU_BRANCH_EN undefined -> State 3 (NOOP).
- PC=0xFF fetch -> PC wraps to 0x00.
- HALT 0x5000 -> Halted=1, State=9 held for 20 cycles regardless of I_Ready; Reset clears to State 0.
